// File: rtl/elim_sequencer_if.sv
// elim_sequencer_if: request/result and board-RAM signals of the elimination sequencer.
// Rev 1.0
`default_nettype none

interface elim_sequencer_if #(
  parameter int COLOR_W = 3
) ();
  logic               start;
  logic               commit;
  logic [3:0]         x;
  logic [3:0]         y;
  logic [5:0]         mem_raddr;
  logic [COLOR_W-1:0] mem_rdata;
  logic               mem_we;
  logic [5:0]         mem_waddr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               busy;
  logic               done;
  logic               cleared;
  logic [6:0]         group_size;
  logic [63:0]        mark_map;

  modport master (
    output start, commit, x, y, mem_rdata,
    input  mem_raddr, mem_we, mem_waddr, mem_wdata,
    input  busy, done, cleared, group_size, mark_map
  );

  modport slave (
    input  start, commit, x, y, mem_rdata,
    output mem_raddr, mem_we, mem_waddr, mem_wdata,
    output busy, done, cleared, group_size, mark_map
  );
endinterface

`default_nettype wire

// File: rtl/elim_sequencer.sv
// elim_sequencer: flood-fills the same-colour region under the cursor; optionally clears it in RAM.
// Rev 1.0
`default_nettype none

module elim_sequencer #(
  parameter int MIN_GROUP = 2,
  parameter int COLOR_W   = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  elim_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_POP, S_NBR, S_CHK, S_CLEAR, S_FIN
  } state_t;

  localparam logic [6:0] c_min_group = 7'(MIN_GROUP);

  state_t             r_state;
  logic               r_commit;
  logic [5:0]         r_cur;
  logic [1:0]         r_dir;
  logic [5:0]         r_idx;
  logic [6:0]         r_sp;
  logic [5:0]         r_stack [64];
  logic [COLOR_W-1:0] r_target;

  logic [5:0]         w_nbr_addr;
  logic               w_nbr_ok;
  logic [5:0]         w_sp_m1;
  logic [5:0]         w_idx_p1;

  assign bus.mem_wdata = '0;
  assign w_sp_m1       = r_sp[5:0] - 6'd1;
  assign w_idx_p1      = r_idx + 6'd1;

  // Neighbour of r_cur in direction r_dir; edges never wrap to the adjacent row/column.
  always_comb begin
    w_nbr_addr = r_cur;
    w_nbr_ok   = 1'b0;
    case (r_dir)
      2'd0: begin w_nbr_addr = r_cur - 6'd1; w_nbr_ok = (r_cur[2:0] != 3'd0); end
      2'd1: begin w_nbr_addr = r_cur + 6'd1; w_nbr_ok = (r_cur[2:0] != 3'd7); end
      2'd2: begin w_nbr_addr = r_cur - 6'd8; w_nbr_ok = (r_cur[5:3] != 3'd0); end
      default: begin w_nbr_addr = r_cur + 6'd8; w_nbr_ok = (r_cur[5:3] != 3'd7); end
    endcase
    w_nbr_ok = w_nbr_ok && !bus.mark_map[w_nbr_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_commit       <= 1'b0;
      r_cur          <= '0;
      r_dir          <= '0;
      r_idx          <= '0;
      r_sp           <= '0;
      r_target       <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.cleared    <= 1'b0;
      bus.group_size <= '0;
      bus.mark_map   <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_raddr  <= '0;
      bus.mem_waddr  <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            bus.group_size <= '0;
            bus.mark_map   <= '0;
            bus.cleared    <= 1'b0;
            r_sp           <= '0;
            if (bus.x > 4'd7 || bus.y > 4'd7) begin
              r_state <= S_FIN;
            end else begin
              r_commit      <= bus.commit;
              r_cur         <= {bus.y[2:0], bus.x[2:0]};
              bus.mem_raddr <= {bus.y[2:0], bus.x[2:0]};
              bus.busy      <= 1'b1;
              r_state       <= S_SEED;
            end
          end
        end
        S_SEED: begin
          if (bus.mem_rdata == '0) begin
            bus.busy <= 1'b0;
            r_state  <= S_FIN;
          end else begin
            r_target             <= bus.mem_rdata;
            bus.mark_map[r_cur]  <= 1'b1;
            r_stack[0]           <= r_cur;
            r_sp                 <= 7'd1;
            bus.group_size       <= 7'd1;
            r_state              <= S_POP;
          end
        end
        S_POP: begin
          if (r_sp == 7'd0) begin
            if (r_commit && bus.group_size >= c_min_group) begin
              r_idx         <= '0;
              bus.mem_we    <= bus.mark_map[0];
              bus.mem_waddr <= '0;
              r_state       <= S_CLEAR;
            end else begin
              bus.busy <= 1'b0;
              r_state  <= S_FIN;
            end
          end else begin
            r_cur   <= r_stack[w_sp_m1];
            r_sp    <= r_sp - 7'd1;
            r_dir   <= '0;
            r_state <= S_NBR;
          end
        end
        S_NBR: begin
          if (w_nbr_ok) begin
            bus.mem_raddr <= w_nbr_addr;
            r_state       <= S_CHK;
          end else if (r_dir == 2'd3) begin
            r_state <= S_POP;
          end else begin
            r_dir <= r_dir + 2'd1;
          end
        end
        S_CHK: begin
          // mem_raddr still holds the neighbour under test.
          if (bus.mem_rdata == r_target) begin
            bus.mark_map[bus.mem_raddr] <= 1'b1;
            r_stack[r_sp[5:0]]          <= bus.mem_raddr;
            r_sp                        <= r_sp + 7'd1;
            bus.group_size              <= bus.group_size + 7'd1;
          end
          if (r_dir == 2'd3) begin
            r_state <= S_POP;
          end else begin
            r_dir   <= r_dir + 2'd1;
            r_state <= S_NBR;
          end
        end
        S_CLEAR: begin
          if (r_idx == 6'd63) begin
            bus.cleared <= 1'b1;
            bus.busy    <= 1'b0;
            r_state     <= S_FIN;
          end else begin
            r_idx         <= w_idx_p1;
            bus.mem_we    <= bus.mark_map[w_idx_p1];
            bus.mem_waddr <= w_idx_p1;
          end
        end
        S_FIN: begin
          bus.done <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_elim_sequencer.sv
// tb_elim_sequencer: directed vectors against a small combinational-read board RAM.
// Rev 1.0
`default_nettype none

module tb_elim_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elim_sequencer_if #(.COLOR_W(3)) bus ();

  elim_sequencer #(.MIN_GROUP(2), .COLOR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [2:0] board [64];
  assign bus.mem_rdata = board[bus.mem_raddr];

  int total = 0;
  int bad   = 0;

  int          lat, ndone, nwr, badwdata, lat_preview, nwe_after;
  logic [63:0] wmask, rmask;
  logic        busy1, cl_at_done, seen_we;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic fill(input logic [2:0] c);
    for (int i = 0; i < 64; i++) board[i] = c;
  endtask

  // Pulses start, then observes every cycle until a few cycles past done (bounded).
  task automatic run_op(input logic [3:0] cx, input logic [3:0] cy, input logic cm, input bit inject);
    lat = -1; ndone = 0; nwr = 0; badwdata = 0; wmask = '0; rmask = '0;
    busy1 = 1'b0; cl_at_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.commit = cm; bus.x = cx; bus.y = cy;
    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (inject && c == 3) begin
        bus.start = 1'b1; bus.commit = 1'b1; bus.x = 4'd0; bus.y = 4'd0;
      end
      if (c == 1) busy1 = bus.busy;
      rmask[bus.mem_raddr] = 1'b1;
      if (bus.mem_we) begin
        nwr++;
        wmask[bus.mem_waddr] = 1'b1;
        if (bus.mem_wdata != 3'd0) badwdata++;
        board[bus.mem_waddr] = bus.mem_wdata;
      end
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin lat = c; cl_at_done = bus.cleared; end
      end
      if (lat >= 0 && c >= lat + 4) break;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.commit = 1'b0; bus.x = '0; bus.y = '0;
    fill(3'd0);
    repeat (3) @(negedge clk);
    check("rst_busy",  64'(bus.busy),       64'd0);
    check("rst_done",  64'(bus.done),       64'd0);
    check("rst_gs",    64'(bus.group_size), 64'd0);
    check("rst_map",   bus.mark_map,        64'd0);
    check("rst_we",    64'(bus.mem_we),     64'd0);
    check("rst_raddr", 64'(bus.mem_raddr),  64'd0);
    rst_n = 1'b1;

    // Isolated seed at (2,3), commit below MIN_GROUP
    fill(3'd1); board[26] = 3'd5;
    run_op(4'd2, 4'd3, 1'b1, 1'b0);
    check("iso_gs",   64'(bus.group_size), 64'd1);
    check("iso_map",  bus.mark_map,        64'h0000_0000_0400_0000);
    check("iso_wr",   64'(nwr),            64'd0);
    check("iso_clr",  64'(cl_at_done),     64'd0);

    // Bottom row preview
    fill(3'd1); for (int i = 56; i < 64; i++) board[i] = 3'd2;
    run_op(4'd0, 4'd7, 1'b0, 1'b0);
    lat_preview = lat;
    check("row_gs",    64'(bus.group_size), 64'd8);
    check("row_map",   bus.mark_map,        64'hFF00_0000_0000_0000);
    check("row_wr",    64'(nwr),            64'd0);
    check("row_ndone", 64'(ndone),          64'd1);
    check("row_busy1", 64'(busy1),          64'd1);

    // Bottom row commit
    fill(3'd1); for (int i = 56; i < 64; i++) board[i] = 3'd2;
    run_op(4'd0, 4'd7, 1'b1, 1'b0);
    check("rowc_wr",    64'(nwr),            64'd8);
    check("rowc_wmask", wmask,               64'hFF00_0000_0000_0000);
    check("rowc_wdata", 64'(badwdata),       64'd0);
    check("rowc_clr",   64'(cl_at_done),     64'd1);
    check("rowc_gs",    64'(bus.group_size), 64'd8);
    check("rowc_lat",   64'(lat),            64'(lat_preview + 64));

    // Whole board one colour
    fill(3'd4);
    run_op(4'd7, 4'd0, 1'b1, 1'b0);
    check("all_gs",    64'(bus.group_size), 64'd64);
    check("all_map",   bus.mark_map,        64'hFFFF_FFFF_FFFF_FFFF);
    check("all_wr",    64'(nwr),            64'd64);
    check("all_wmask", wmask,               64'hFFFF_FFFF_FFFF_FFFF);
    check("all_clr",   64'(cl_at_done),     64'd1);

    // Corner must not wrap to (7,0) or (7,7)
    fill(3'd6); board[0] = 3'd3; board[7] = 3'd3;
    run_op(4'd0, 4'd0, 1'b0, 1'b0);
    check("cor_gs",  64'(bus.group_size), 64'd1);
    check("cor_map", bus.mark_map,        64'd1);
    check("cor_rd7", 64'(rmask[7]),       64'd0);
    check("cor_rd63", 64'(rmask[63]),     64'd0);

    // Invalid coordinate
    run_op(4'd9, 4'd0, 1'b1, 1'b0);
    check("inv_lat", 64'(lat),            64'd2);
    check("inv_gs",  64'(bus.group_size), 64'd0);
    check("inv_map", bus.mark_map,        64'd0);
    check("inv_wr",  64'(nwr),            64'd0);

    // Empty seed
    fill(3'd1); board[10] = 3'd0;
    run_op(4'd2, 4'd1, 1'b1, 1'b0);
    check("emp_lat", 64'(lat),            64'd3);
    check("emp_gs",  64'(bus.group_size), 64'd0);

    // Second start while busy is dropped
    fill(3'd1); for (int i = 56; i < 64; i++) board[i] = 3'd2;
    run_op(4'd0, 4'd7, 1'b0, 1'b1);
    check("bsy_gs",    64'(bus.group_size), 64'd8);
    check("bsy_map",   bus.mark_map,        64'hFF00_0000_0000_0000);
    check("bsy_ndone", 64'(ndone),          64'd1);
    check("bsy_wr",    64'(nwr),            64'd0);

    // Reset during CLEAR
    fill(3'd1); for (int i = 56; i < 64; i++) board[i] = 3'd2;
    @(negedge clk);
    bus.start = 1'b1; bus.commit = 1'b1; bus.x = 4'd0; bus.y = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    seen_we = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.mem_we) begin seen_we = 1'b1; break; end
      @(negedge clk);
    end
    check("rstc_seen", 64'(seen_we), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstc_we",   64'(bus.mem_we), 64'd0);
    check("rstc_busy", 64'(bus.busy),   64'd0);
    rst_n = 1'b1;
    ndone = 0; nwe_after = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.mem_we) nwe_after++;
    end
    check("rstc_ndone", 64'(ndone),     64'd0);
    check("rstc_nwe",   64'(nwe_after), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
